// File: rtl/risxv_skid_stage.sv
// risXv elastic pipeline register with valid/ready flow control.
// SKID=1: 2-entry skid buffer, registered in_ready; SKID=0: single slot.
module risxv_skid_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter bit               SKID     = 1'b1,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] skid_q;

    // in_ready comes from flops only, so out_ready never
    // reaches upstream combinationally
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;

    // occupancy FSM; main slot feeds output, skid slot
    // absorbs the one entry taken while the output stalls
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= EMPTY;
        main_q  <= RST_DATA;
        skid_q  <= RST_DATA;
      end else if (flush) begin
        state_q <= EMPTY;
        main_q  <= RST_DATA;
        skid_q  <= RST_DATA;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_q <= BUSY;
              main_q  <= in_data;
            end
          end
          BUSY: begin
            unique case (1'b1)
              in_fire & ~out_fire: begin
                state_q <= FULL;
                skid_q  <= in_data;
              end
              ~in_fire & out_fire: begin
                state_q <= EMPTY;
              end
              in_fire & out_fire: begin
                main_q <= in_data;
              end
              default: ;
            endcase
          end
          FULL: begin
            if (out_fire) begin
              state_q <= BUSY;
              main_q  <= skid_q;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end else begin : g_single
    logic valid_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};

    // single slot; refills on the same edge it drains
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        main_q  <= RST_DATA;
      end else if (flush) begin
        valid_q <= 1'b0;
        main_q  <= RST_DATA;
      end else if (in_fire) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  property p_stall_stable;
    @(posedge clk) disable iff (!rst)
      (out_valid && !out_ready && !flush)
      |=> $stable(out_data);
  endproperty

  a_stall_stable: assert property (p_stall_stable);

endmodule

// File: tb/tb_risxv_skid_stage.sv
// Bench for risxv_skid_stage: both SKID variants side by side,
// queue-based reference model and output scoreboard.
module tb_risxv_skid_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        ir1, ir0;
  logic        ov1, ov0;
  logic        ordy1, ordy0;
  logic [31:0] od1, od0;
  logic [1:0]  occ1, occ0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] outs1[$];
  logic [31:0] outs0[$];
  logic        exp_ir1 = 1'b1;
  logic        exp_ir0 = 1'b1;

  risxv_skid_stage #(
    .WIDTH(32), .SKID(1'b1), .RST_DATA(32'h0)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1),
    .out_ready(ordy1), .out_data(od1),
    .occupancy(occ1)
  );

  risxv_skid_stage #(
    .WIDTH(32), .SKID(1'b0), .RST_DATA(32'h0)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0),
    .out_ready(ordy0), .out_data(od0),
    .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // monitor, skid variant: capacity 2
  initial forever begin
    @(posedge clk);
    #3;
    if (rst) begin
      exp_ir1 = (q1.size() < 2);
      chk("occ1", 32'(occ1), 32'(q1.size()));
      chk("out_valid1", 32'(ov1),
          32'(q1.size() != 0));
      chk("in_ready1", 32'(ir1), 32'(exp_ir1));
      if (q1.size() != 0) begin
        chk("out_data1", od1, q1[0]);
        if (ordy1) begin
          outs1.push_back(od1);
          void'(q1.pop_front());
        end
      end
    end
  end

  // monitor, single-slot variant: capacity 1, ready passes through
  initial forever begin
    @(posedge clk);
    #3;
    if (rst) begin
      exp_ir0 = (q0.size() == 0) || ordy0;
      chk("occ0", 32'(occ0), 32'(q0.size()));
      chk("out_valid0", 32'(ov0),
          32'(q0.size() != 0));
      chk("in_ready0", 32'(ir0), 32'(exp_ir0));
      if (q0.size() != 0) begin
        chk("out_data0", od0, q0[0]);
        if (ordy0) begin
          outs0.push_back(od0);
          void'(q0.pop_front());
        end
      end
    end
  end

  // drive one cycle, then record what the model says was accepted
  task automatic cycle(input logic v,
                       input logic [31:0] d,
                       input logic f,
                       input logic r1,
                       input logic r0);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    flush    = f;
    ordy1    = r1;
    ordy0    = r0;
    #5;
    if (rst) begin
      if (f) begin
        q1.delete();
        q0.delete();
      end else if (v) begin
        if (exp_ir1) q1.push_back(d);
        if (exp_ir0) q0.push_back(d);
      end
    end
  endtask

  initial begin
    int n;
    bit took;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ordy1    = 1'b0;
    ordy0    = 1'b0;

    // reset with traffic offered
    #2;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    repeat (3) @(posedge clk);
    #6;
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_od1", od1, 0);
    chk("rst_occ1", 32'(occ1), 0);
    chk("rst_ov0", 32'(ov0), 0);
    chk("rst_od0", od0, 0);
    chk("rst_occ0", 32'(occ0), 0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_ir1", 32'(ir1), 1);

    // streaming
    for (int i = 0; i < 6; i++) begin
      cycle(i < 3, 32'(i + 1), 1'b0, 1'b1, 1'b1);
      if (i >= 1 && i <= 3) begin
        chk("stream_data", od1, 32'(i));
        chk("stream_occ", 32'(occ1), 1);
        chk("stream_ir", 32'(ir1), 1);
      end
    end

    // backpressure into the skid slot
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    chk("bp_occ", 32'(occ1), 2);
    chk("bp_ir", 32'(ir1), 0);
    n = outs1.size();
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b1);
    chk("bp_hold_occ", 32'(occ1), 2);
    took = 1'b0;
    for (int i = 0; i < 8 && !took; i++) begin
      cycle(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
      took = exp_ir1;
    end
    chk("bp_c_taken", 32'(took), 1);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("bp_count", 32'(outs1.size() - n), 3);
    if (outs1.size() >= n + 3) begin
      chk("bp_out0", outs1[n], 32'hA);
      chk("bp_out1", outs1[n+1], 32'hB);
      chk("bp_out2", outs1[n+2], 32'hC);
    end

    // flush while full, with a coincident offer
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("fl_ov", 32'(ov1), 0);
    chk("fl_occ", 32'(occ1), 0);
    chk("fl_od", od1, 0);
    n = outs1.size();
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("fl_no_out", 32'(outs1.size()), 32'(n));

    // single slot with toggling out_ready
    n = outs0.size();
    cycle(1'b1, 32'h10, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
    chk("s0_ir_lo", 32'(ir0), 0);
    cycle(1'b1, 32'h11, 1'b0, 1'b1, 1'b1);
    chk("s0_ir_hi", 32'(ir0), 1);
    cycle(1'b1, 32'h12, 1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("s0_count", 32'(outs0.size() - n), 3);
    if (outs0.size() >= n + 3) begin
      chk("s0_out0", outs0[n], 32'h10);
      chk("s0_out1", outs0[n+1], 32'h11);
      chk("s0_out2", outs0[n+2], 32'h12);
    end

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0,
            $urandom,
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0);
    end
    repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("drain_ov1", 32'(ov1), 0);
    chk("drain_ov0", 32'(ov0), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
